// File: rtl/mem_rd_arbiter_if.sv
// mem_rd_arbiter_if: IF/MEM requester ports and AXI4-Lite read channel of the read arbiter
interface mem_rd_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_en;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] m_araddr;
    logic              m_arvalid;
    logic              m_arready;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rvalid;
    logic              m_rready;
    logic              busy;
    logic              err;

    modport slave (
        input  if_en, if_addr, mem_en, mem_addr, m_arready, m_rdata, m_rresp, m_rvalid,
        output if_valid, if_rdata, mem_valid, mem_rdata, m_araddr, m_arvalid, m_rready, busy, err
    );

    modport master (
        output if_en, if_addr, mem_en, mem_addr, m_arready, m_rdata, m_rresp, m_rvalid,
        input  if_valid, if_rdata, mem_valid, mem_rdata, m_araddr, m_arvalid, m_rready, busy, err
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: shares one AXI4-Lite read port between IF and MEM, one transaction in flight
// Define ARB_RR_EN for round-robin on simultaneous requests; otherwise MEM has fixed priority.
module mem_rd_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input logic             ACLK,
    input logic             ARESETn,
    mem_rd_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, AR, R} state_t;
    localparam logic G_IF  = 1'b0;
    localparam logic G_MEM = 1'b1;

    state_t            state, state_nxt;
    logic              grant, last_grant, grant_nxt;
    logic              if_req, mem_req, done;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
    logic              if_valid_q, mem_valid_q, err_q;

    // a requester still showing its valid pulse is dropping en and must not be re-served
    assign if_req  = bus.if_en & ~if_valid_q;
    assign mem_req = bus.mem_en & ~mem_valid_q;
    assign done    = (state == R) & bus.m_rvalid;

`ifdef ARB_RR_EN
    assign grant_nxt = (if_req & mem_req) ? ~last_grant : mem_req;
`else
    // MEM always wins; last_grant is tracked but does not steer the choice
    assign grant_nxt = (if_req & mem_req) ? (G_MEM | last_grant) : mem_req;
`endif

    // state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state: AR holds until arready, R holds until rvalid
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = (if_req | mem_req) ? AR : IDLE;
            AR:      state_nxt = bus.m_arready ? R : AR;
            R:       state_nxt = bus.m_rvalid ? IDLE : R;
            default: state_nxt = IDLE;
        endcase
    end

    // bus handshakes decode from registered state only
    always_comb begin
        bus.m_arvalid = (state == AR);
        bus.m_rready  = (state == R);
        bus.busy      = (state != IDLE);
    end

    // grant/address latch, data capture, valid pulses and sticky error
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            grant       <= G_MEM;
            last_grant  <= G_MEM;
            addr_q      <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            if (state == IDLE && (if_req | mem_req)) begin
                grant  <= grant_nxt;
                addr_q <= (grant_nxt == G_MEM) ? bus.mem_addr : bus.if_addr;
            end
            if (done) begin
                last_grant <= grant;
                err_q      <= err_q | (bus.m_rresp != 2'b00);
                if (grant == G_MEM) begin
                    mem_rdata_q <= bus.m_rdata;
                    mem_valid_q <= bus.mem_en;
                end else begin
                    if_rdata_q <= bus.m_rdata;
                    if_valid_q <= bus.if_en;
                end
            end
        end
    end

    assign bus.m_araddr  = addr_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: vector table of single reads plus arbitration, flush and reset sequences
module tb_mem_rd_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    typedef struct {
        logic          who;
        logic [AW-1:0] addr;
        int            ar_dly;
        int            r_dly;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        int            exp_lat;
        logic          exp_err;
    } vec_t;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    int checks = 0;
    int failures = 0;
    int ar_dly = 0, r_dly = 0, ar_cnt = 0, r_cnt = 0, ar_hs = 0, r_hs = 0;
    logic [DW-1:0] rsp_data = '0;
    logic [1:0] rsp_resp = 2'b00;
    vec_t vecs[5];
    int cyc, got, bad, other, ar0, r0, nv, mem_cyc, if_cyc;
    logic first_mem;

    always #5 ACLK = ~ACLK;

    mem_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // AXI read slave: arready after ar_dly cycles of arvalid, rvalid after r_dly cycles of rready
    initial begin
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rdata   = '0;
        bus.m_rresp   = 2'b00;
        forever begin
            @(negedge ACLK);
            if (bus.m_arvalid) begin
                bus.m_arready = (ar_cnt == ar_dly);
                if (ar_cnt == ar_dly) ar_hs++;
                ar_cnt++;
            end else begin
                bus.m_arready = 1'b0;
                ar_cnt = 0;
            end
            if (bus.m_rready) begin
                bus.m_rvalid = (r_cnt == r_dly);
                bus.m_rdata  = rsp_data;
                bus.m_rresp  = rsp_resp;
                if (r_cnt == r_dly) r_hs++;
                r_cnt++;
            end else begin
                bus.m_rvalid = 1'b0;
                r_cnt = 0;
            end
        end
    end

    initial begin
        vecs[0] = '{1'b0, 64'h8000_0000, 0, 0, 64'h13, 2'b00, 3, 1'b0};
        vecs[1] = '{1'b1, 64'h1000, 0, 0, 64'hdead_beef, 2'b00, 3, 1'b0};
        vecs[2] = '{1'b0, 64'h8000_0004, 4, 3, 64'h1234_5678_9abc_def0, 2'b00, 10, 1'b0};
        vecs[3] = '{1'b1, 64'h2008, 1, 0, 64'hcafe, 2'b00, 4, 1'b0};
        vecs[4] = '{1'b1, 64'h3000, 0, 2, 64'ha5a5_a5a5, 2'b10, 5, 1'b1};

        bus.if_en = 1'b0;
        bus.if_addr = '0;
        bus.mem_en = 1'b0;
        bus.mem_addr = '0;

        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_arvalid", bus.m_arvalid, 0);
        chk("rst_rready", bus.m_rready, 0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_mem_valid", bus.mem_valid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_araddr", bus.m_araddr, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_mem_rdata", bus.mem_rdata, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            ar_dly = vecs[i].ar_dly;
            r_dly = vecs[i].r_dly;
            rsp_data = vecs[i].data;
            rsp_resp = vecs[i].resp;
            if (vecs[i].who) begin
                bus.mem_en = 1'b1;
                bus.mem_addr = vecs[i].addr;
            end else begin
                bus.if_en = 1'b1;
                bus.if_addr = vecs[i].addr;
            end
            ar0 = ar_hs;
            cyc = 0;
            got = 0;
            bad = 0;
            other = 0;
            while (got == 0 && cyc < 40) begin
                @(posedge ACLK);
                #1;
                cyc++;
                if (bus.m_arvalid && bus.m_araddr !== vecs[i].addr) bad++;
                if (vecs[i].who ? bus.mem_valid : bus.if_valid) got = 1;
                if (vecs[i].who ? bus.if_valid : bus.mem_valid) other++;
                if (cyc == 2) begin
                    if (vecs[i].who) bus.mem_addr = ~vecs[i].addr;
                    else bus.if_addr = ~vecs[i].addr;
                end
            end
            chk($sformatf("v%0d_got_valid", i), got, 1);
            chk($sformatf("v%0d_latency", i), cyc, vecs[i].exp_lat);
            chk($sformatf("v%0d_rdata", i), vecs[i].who ? bus.mem_rdata : bus.if_rdata, vecs[i].data);
            chk($sformatf("v%0d_araddr_stable", i), bad, 0);
            chk($sformatf("v%0d_ar_count", i), ar_hs - ar0, 1);
            chk($sformatf("v%0d_other_valid", i), other, 0);
            chk($sformatf("v%0d_err", i), bus.err, vecs[i].exp_err);
            @(negedge ACLK);
            bus.if_en = 1'b0;
            bus.mem_en = 1'b0;
            @(posedge ACLK);
            #1;
            chk($sformatf("v%0d_single_pulse", i), vecs[i].who ? bus.mem_valid : bus.if_valid, 0);
            chk($sformatf("v%0d_idle", i), bus.busy, 0);
        end

        rsp_resp = 2'b00;
        repeat (3) @(posedge ACLK);
        #1;
        chk("err_sticky", bus.err, 1);
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        chk("err_cleared", bus.err, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;

`ifdef ARB_RR_EN
        first_mem = 1'b0;
`else
        first_mem = 1'b1;
`endif
        @(negedge ACLK);
        ar_dly = 0;
        r_dly = 0;
        rsp_data = 64'h55;
        bus.if_en = 1'b1;
        bus.if_addr = 64'h100;
        bus.mem_en = 1'b1;
        bus.mem_addr = 64'h200;
        mem_cyc = 0;
        if_cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge ACLK);
            #1;
            if (c == 1) chk("arb_first_addr", bus.m_araddr, first_mem ? 64'h200 : 64'h100);
            if (c == 4) chk("arb_second_addr", bus.m_araddr, first_mem ? 64'h100 : 64'h200);
            if (bus.mem_valid) begin
                mem_cyc = c;
                bus.mem_en = 1'b0;
            end
            if (bus.if_valid) begin
                if_cyc = c;
                bus.if_en = 1'b0;
            end
        end
        chk("arb_mem_cycle", mem_cyc, first_mem ? 6'd3 : 6'd6);
        chk("arb_if_cycle", if_cyc, first_mem ? 6'd6 : 6'd3);

        @(negedge ACLK);
        r_dly = 2;
        rsp_data = 64'hf1f1;
        bus.if_en = 1'b1;
        bus.if_addr = 64'h300;
        r0 = r_hs;
        nv = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge ACLK);
            #1;
            if (c == 2) begin
                chk("flush_in_r", bus.m_rready, 1);
                bus.if_en = 1'b0;
            end
            if (bus.if_valid) nv++;
        end
        chk("flush_no_valid", nv, 0);
        chk("flush_r_done", r_hs - r0, 1);
        chk("flush_idle", bus.busy, 0);
        chk("flush_rdata", bus.if_rdata, 64'hf1f1);

        @(negedge ACLK);
        ar_dly = 8;
        r_dly = 0;
        bus.if_en = 1'b1;
        bus.if_addr = 64'h400;
        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_ar_before", bus.m_arvalid, 1);
        ARESETn = 1'b0;
        #1;
        chk("rst_ar_arvalid", bus.m_arvalid, 0);
        chk("rst_ar_busy", bus.busy, 0);
        bus.if_en = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge ACLK);
            #1;
            if (bus.if_valid || bus.mem_valid || bus.m_arvalid) nv++;
        end
        chk("rst_ar_quiet", nv, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
